// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / load-store) arbiter in front of a single fixed-latency RAM port.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin on conflict; otherwise data side always wins.
module mem_arbiter #(
    parameter int RAM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    output logic        ram_en,
    output logic        ram_we,
    output logic [3:0]  ram_wstrb,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_t;

    localparam logic [2:0] LAST_CNT = 3'(RAM_LATENCY - 1);

    state_t      state, state_nxt;
    owner_t      owner;
    logic [2:0]  cnt;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        lat_we;
    logic [3:0]  lat_wstrb;
    logic        pick_d;
    logic        any_req;
    logic        final_wait;

    assign any_req    = if_req | d_req;
    assign final_wait = (state == WAIT) && (cnt == LAST_CNT);

`ifdef ARB_ROUND_ROBIN_EN
    owner_t last_served;

    // On conflict the side that was not served most recently wins.
    assign pick_d = d_req && (!if_req || last_served == OWN_IF);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_served <= OWN_IF;
        end else if (state == ISSUE) begin
            last_served <= owner;
        end
    end
`else
    assign pick_d = d_req;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (final_wait) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // RAM-side signals and grants are live only during the single ISSUE cycle.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_wstrb = 4'h0;
        ram_addr  = 32'h0;
        ram_wdata = 32'h0;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        if (state == ISSUE) begin
            ram_en    = 1'b1;
            ram_we    = lat_we;
            ram_wstrb = lat_wstrb;
            ram_addr  = lat_addr;
            ram_wdata = lat_wdata;
            if_gnt    = (owner == OWN_IF);
            d_gnt     = (owner == OWN_D);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            cnt       <= 3'd0;
            lat_addr  <= 32'h0;
            lat_wdata <= 32'h0;
            lat_we    <= 1'b0;
            lat_wstrb <= 4'h0;
            if_rvalid <= 1'b0;
            if_rdata  <= 32'h0;
            d_rvalid  <= 1'b0;
            d_rdata   <= 32'h0;
        end else begin
            state     <= state_nxt;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;

            if (state == IDLE && any_req) begin
                if (pick_d) begin
                    owner     <= OWN_D;
                    lat_addr  <= d_addr;
                    lat_we    <= d_we;
                    lat_wdata <= d_we ? d_wdata : 32'h0;
                    lat_wstrb <= d_we ? d_wstrb : 4'h0;
                end else begin
                    owner     <= OWN_IF;
                    lat_addr  <= if_addr;
                    lat_we    <= 1'b0;
                    lat_wdata <= 32'h0;
                    lat_wstrb <= 4'h0;
                end
            end

            if (state == ISSUE) begin
                cnt <= 3'd0;
            end

            if (state == WAIT) begin
                cnt <= cnt + 3'd1;
                if (final_wait) begin
                    if (owner == OWN_IF) begin
                        if_rvalid <= 1'b1;
                        if_rdata  <= ram_rdata;
                    end else begin
                        d_rvalid <= 1'b1;
                        // Stores complete with zero data rather than whatever the RAM returns.
                        d_rdata  <= lat_we ? 32'h0 : ram_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at RAM_LATENCY=1 and one at RAM_LATENCY=4, each with a small RAM model.
// Build with ARB_ROUND_ROBIN_EN defined to expect round-robin conflict order.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        ram_en, ram_we;
    logic [3:0]  ram_wstrb;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    logic        if4_gnt, if4_rvalid;
    logic [31:0] if4_rdata;
    logic        d4_req, d4_we;
    logic [31:0] d4_addr, d4_wdata;
    logic [3:0]  d4_wstrb;
    logic        d4_gnt, d4_rvalid;
    logic [31:0] d4_rdata;
    logic        ram4_en, ram4_we;
    logic [3:0]  ram4_wstrb;
    logic [31:0] ram4_addr, ram4_wdata, ram4_rdata;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.RAM_LATENCY(1)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_wstrb(ram_wstrb), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    mem_arbiter #(.RAM_LATENCY(4)) dut4 (
        .clk(clk), .reset(reset),
        .if_req(1'b0), .if_addr(32'h0), .if_gnt(if4_gnt), .if_rvalid(if4_rvalid), .if_rdata(if4_rdata),
        .d_req(d4_req), .d_we(d4_we), .d_addr(d4_addr), .d_wdata(d4_wdata), .d_wstrb(d4_wstrb),
        .d_gnt(d4_gnt), .d_rvalid(d4_rvalid), .d_rdata(d4_rdata),
        .ram_en(ram4_en), .ram_we(ram4_we), .ram_wstrb(ram4_wstrb), .ram_addr(ram4_addr),
        .ram_wdata(ram4_wdata), .ram_rdata(ram4_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h10) ? 32'h0050_0093 : (a ^ 32'hA5A5_0000);
    endfunction

    // RAM models: data is valid exactly RAM_LATENCY edges after the ram_en edge, garbage otherwise.
    logic        p1_v;
    logic [31:0] p1_d;
    always @(posedge clk) begin
        p1_v <= ram_en;
        p1_d <= mem_word(ram_addr);
    end
    assign ram_rdata = p1_v ? p1_d : 32'hBAD0_BAD0;

    logic [3:0]  p4_v;
    logic [31:0] p4_d [4];
    always @(posedge clk) begin
        p4_v <= {p4_v[2:0], ram4_en};
        p4_d[0] <= mem_word(ram4_addr);
        for (int i = 1; i < 4; i++) p4_d[i] <= p4_d[i-1];
    end
    assign ram4_rdata = p4_v[3] ? p4_d[3] : 32'hBAD0_BAD0;

    task automatic test_reset();
        reset = 1'b1;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
        d4_req = 0; d4_we = 0; d4_addr = 0; d4_wdata = 0; d4_wstrb = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({if_gnt, if_rvalid, d_gnt, d_rvalid, ram_en, ram_we} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl got %b exp 000000", {if_gnt, if_rvalid, d_gnt, d_rvalid, ram_en, ram_we});
        end
        checks++;
        if ({if_rdata, d_rdata, ram_addr, ram_wdata, ram_wstrb} !== 132'h0) begin
            errors++; $display("FAIL reset_data got %h exp 0", {if_rdata, d_rdata, ram_addr, ram_wdata, ram_wstrb});
        end
        checks++;
        if ({if4_gnt, if4_rvalid, d4_gnt, d4_rvalid, ram4_en, d4_rdata} !== 37'h0) begin
            errors++; $display("FAIL reset_dut4 got %h exp 0", {if4_gnt, if4_rvalid, d4_gnt, d4_rvalid, ram4_en, d4_rdata});
        end
        reset = 1'b0;
    endtask

    task automatic test_fetch();
        if_req = 1'b1; if_addr = 32'h10;
        @(negedge clk);
        checks++;
        if ({ram_en, if_gnt, d_gnt, ram_we} !== 4'b1100) begin
            errors++; $display("FAIL fetch_issue got %b exp 1100", {ram_en, if_gnt, d_gnt, ram_we});
        end
        checks++;
        if (ram_addr !== 32'h10 || ram_wstrb !== 4'h0) begin
            errors++; $display("FAIL fetch_addr got %h/%h exp 00000010/0", ram_addr, ram_wstrb);
        end
        if_req = 1'b0; if_addr = 32'h0;
        @(negedge clk);
        checks++;
        if ({ram_en, if_gnt, if_rvalid} !== 3'b000 || ram_addr !== 32'h0) begin
            errors++; $display("FAIL fetch_wait got %b addr %h exp 000 addr 0", {ram_en, if_gnt, if_rvalid}, ram_addr);
        end
        @(negedge clk);
        checks++;
        if (if_rvalid !== 1'b1 || d_rvalid !== 1'b0 || if_rdata !== 32'h0050_0093) begin
            errors++; $display("FAIL fetch_rvalid got %b/%b data %h exp 1/0 data 00500093", if_rvalid, d_rvalid, if_rdata);
        end
        @(negedge clk);
        checks++;
        if (if_rvalid !== 1'b0 || if_rdata !== 32'h0050_0093) begin
            errors++; $display("FAIL fetch_hold got %b data %h exp 0 data 00500093", if_rvalid, if_rdata);
        end
    endtask

    task automatic test_load_store();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        @(negedge clk);
        checks++;
        if ({ram_en, d_gnt, if_gnt, ram_we} !== 4'b1100 || ram_addr !== 32'h40) begin
            errors++; $display("FAIL load_issue got %b addr %h exp 1100 addr 00000040", {ram_en, d_gnt, if_gnt, ram_we}, ram_addr);
        end
        d_req = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'hA5A5_0040) begin
            errors++; $display("FAIL load_rvalid got %b data %h exp 1 data a5a50040", d_rvalid, d_rdata);
        end
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
        @(negedge clk);
        checks++;
        if ({ram_en, ram_we, d_gnt, if_gnt} !== 4'b1110) begin
            errors++; $display("FAIL store_issue got %b exp 1110", {ram_en, ram_we, d_gnt, if_gnt});
        end
        checks++;
        if (ram_addr !== 32'h100 || ram_wdata !== 32'hDEAD_BEEF || ram_wstrb !== 4'hF) begin
            errors++; $display("FAIL store_bus got %h %h %h exp 00000100 deadbeef f", ram_addr, ram_wdata, ram_wstrb);
        end
        d_req = 1'b0; d_we = 1'b0; d_wdata = 32'h0; d_wstrb = 4'h0;
        repeat (2) @(negedge clk);
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h0 || if_rvalid !== 1'b0) begin
            errors++; $display("FAIL store_done got %b data %h if_rvalid %b exp 1 data 0 if_rvalid 0", d_rvalid, d_rdata, if_rvalid);
        end
        checks++;
        if (if_rdata !== 32'h0050_0093) begin
            errors++; $display("FAIL if_rdata_hold got %h exp 00500093", if_rdata);
        end
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h104; d_wdata = 32'h1234_5678; d_wstrb = 4'b0101;
        @(negedge clk);
        checks++;
        if (ram_we !== 1'b1 || ram_wstrb !== 4'b0101 || ram_wdata !== 32'h1234_5678) begin
            errors++; $display("FAIL store_partial got %b %b %h exp 1 0101 12345678", ram_we, ram_wstrb, ram_wdata);
        end
        d_req = 1'b0; d_we = 1'b0; d_wdata = 32'h0; d_wstrb = 4'h0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_conflict();
        logic [3:0] exp_d;
        int         cyc, last_issue, if_rv, d_rv;
        logic       found;
`ifdef ARB_ROUND_ROBIN_EN
        exp_d = 4'b0101;
`else
        exp_d = 4'b1111;
`endif
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        if_req = 1'b1; if_addr = 32'h20; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        cyc = 0; last_issue = 0; if_rv = 0; d_rv = 0;
        for (int t = 0; t < 4; t++) begin
            found = 1'b0;
            for (int c = 0; c < 6 && !found; c++) begin
                @(negedge clk);
                cyc++;
                if (if_rvalid) if_rv++;
                if (d_rvalid) d_rv++;
                if (if_gnt || d_gnt) found = 1'b1;
            end
            checks++;
            if (!found || {d_gnt, if_gnt} !== {exp_d[t], ~exp_d[t]}) begin
                errors++; $display("FAIL conflict_grant%0d got d/if %b%b exp %b%b", t, d_gnt, if_gnt, exp_d[t], ~exp_d[t]);
            end
            checks++;
            if (ram_addr !== (exp_d[t] ? 32'h300 : 32'h20)) begin
                errors++; $display("FAIL conflict_addr%0d got %h exp %h", t, ram_addr, exp_d[t] ? 32'h300 : 32'h20);
            end
            if (t > 0) begin
                checks++;
                if (cyc - last_issue != 3) begin
                    errors++; $display("FAIL conflict_spacing%0d got %0d exp 3", t, cyc - last_issue);
                end
            end
            last_issue = cyc;
        end
        if_req = 1'b0; d_req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (if_rvalid) if_rv++;
            if (d_rvalid) d_rv++;
        end
        checks++;
        if (d_rv != 4 - if_rv || if_rv != (exp_d[1] ? 0 : 2)) begin
            errors++; $display("FAIL conflict_rvalids got if %0d d %0d exp if %0d", if_rv, d_rv, exp_d[1] ? 0 : 2);
        end
    endtask

    task automatic test_latency4();
        int rv_k, en_cnt;
        rv_k = -1; en_cnt = 0;
        d4_req = 1'b1; d4_we = 1'b0; d4_addr = 32'h200;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k == 0) begin
                checks++;
                if ({ram4_en, d4_gnt} !== 2'b11 || ram4_addr !== 32'h200) begin
                    errors++; $display("FAIL lat4_issue got %b addr %h exp 11 addr 00000200", {ram4_en, d4_gnt}, ram4_addr);
                end
                d4_req = 1'b0;
            end
            if (ram4_en) en_cnt++;
            if (d4_rvalid && rv_k < 0) rv_k = k;
        end
        checks++;
        if (rv_k != 5) begin
            errors++; $display("FAIL lat4_rvalid_cycle got %0d exp 5", rv_k);
        end
        checks++;
        if (en_cnt != 1) begin
            errors++; $display("FAIL lat4_ram_en_count got %0d exp 1", en_cnt);
        end
        checks++;
        if (d4_rdata !== 32'hA5A5_0200) begin
            errors++; $display("FAIL lat4_rdata got %h exp a5a50200", d4_rdata);
        end
    endtask

    task automatic test_reset_in_wait();
        if_req = 1'b1; if_addr = 32'h10;
        @(negedge clk);
        checks++;
        if (if_gnt !== 1'b1) begin
            errors++; $display("FAIL rst_wait_issue got %b exp 1", if_gnt);
        end
        if_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({if_gnt, if_rvalid, d_gnt, d_rvalid, ram_en, if_rdata, d_rdata, ram_addr} !== 101'h0) begin
            errors++; $display("FAIL rst_wait_outputs got rv %b en %b if_rdata %h exp all 0", if_rvalid, ram_en, if_rdata);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (if_rvalid !== 1'b0) begin
            errors++; $display("FAIL rst_wait_no_rvalid got %b exp 0", if_rvalid);
        end
        if_req = 1'b1; if_addr = 32'h24;
        @(negedge clk);
        checks++;
        if (if_gnt !== 1'b1 || ram_addr !== 32'h24) begin
            errors++; $display("FAIL rst_wait_reissue got %b addr %h exp 1 addr 00000024", if_gnt, ram_addr);
        end
        if_req = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'hA5A5_0024) begin
            errors++; $display("FAIL rst_wait_refetch got %b data %h exp 1 data a5a50024", if_rvalid, if_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_load_store();
        test_conflict();
        test_latency4();
        test_reset_in_wait();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

endmodule
